// File: rtl/latch_write_sequencer.sv
// Round-robin write sequencer for a shared bank of level-sensitive D latches.
// Drives registered D/EN with a setup / enable-pulse / hold sequence, then acks the winner.
module latch_write_sequencer #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned SETUP = 1,
    parameter int unsigned PULSE = 2,
    parameter int unsigned HOLD  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] din,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      D,
    output logic              EN,
    output logic              busy
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     win_q, win_d;
    logic [W-1:0]      d_q, d_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic [NREQ-1:0]   ack_q, ack_d;

    logic              grant_found;
    logic [IW-1:0]     grant_idx;
    logic [IW-1:0]     cand;
    int unsigned       idx;

    // First high request at or after ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx  = (32'(ptr_q) + i) % NREQ;
            cand = IW'(idx);
            if (!grant_found && req[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        d_d     = d_q;

        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    state_d = S_SETUP;
                    cnt_d   = 8'(SETUP - 1);
                    d_d     = din[grant_idx*W +: W];
                    win_d   = grant_idx;
                    ptr_d   = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = 8'(PULSE - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = 8'(HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        en_d   = (state_d == S_PULSE);
        busy_d = (state_d != S_IDLE);
        ack_d  = '0;
        if (state_d == S_DONE) begin
            ack_d[win_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            d_q     <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            d_q     <= d_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign D    = d_q;
    assign EN   = en_q;
    assign busy = busy_q;
    assign ack  = ack_q;
endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer: default timing on one instance,
// SETUP=3/PULSE=1/HOLD=2 timing on a second instance.
module tb_latch_write_sequencer;
    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  ack;
    logic [7:0]  d_out;
    logic        en;
    logic        busy;

    logic [3:0]  req2;
    logic [31:0] din2;
    logic [3:0]  ack2;
    logic [7:0]  d_out2;
    logic        en2;
    logic        busy2;

    int n_pass;
    int n_total;

    latch_write_sequencer #(.NREQ(4), .W(8), .SETUP(1), .PULSE(2), .HOLD(1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .din  (din),
        .ack  (ack),
        .D    (d_out),
        .EN   (en),
        .busy (busy)
    );

    latch_write_sequencer #(.NREQ(4), .W(8), .SETUP(3), .PULSE(1), .HOLD(2)) dut2 (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req2),
        .din  (din2),
        .ack  (ack2),
        .D    (d_out2),
        .EN   (en2),
        .busy (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called in cycle 0 with the request already driven; returns in cycle 6.
    // The winner's req is dropped on the edge that ends the ack cycle.
    task automatic run_txn(input int w, input logic [7:0] data, input string tag);
        logic [3:0] onehot;
        onehot = 4'b0001 << w;
        for (int c = 1; c <= 6; c++) begin
            tick();
            check($sformatf("%s_en_c%0d", tag, c), 32'(en), 32'((c == 2) || (c == 3)));
            check($sformatf("%s_ack_c%0d", tag, c), 32'(ack), (c == 5) ? 32'(onehot) : 32'h0);
            check($sformatf("%s_busy_c%0d", tag, c), 32'(busy), 32'(c <= 5));
            if (c <= 5) check($sformatf("%s_d_c%0d", tag, c), 32'(d_out), 32'(data));
            if (c == 5) req[w] = 1'b0;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        req     = 4'b1111;
        din     = 32'h44332211;
        req2    = 4'b0000;
        din2    = 32'h0;

        // Reset held with all requests high.
        repeat (3) tick();
        check("rst_en", 32'(en), 32'h0);
        check("rst_d", 32'(d_out), 32'h0);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst2_en", 32'(en2), 32'h0);
        check("rst2_busy", 32'(busy2), 32'h0);

        // Release: this cycle is cycle 0 of the first grant (requester 0).
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [7:0] exp_data;
            exp_data = din[(k % 4) * 8 +: 8];
            run_txn(k % 4, exp_data, $sformatf("rr%0d", k));
            if (k < 4) req[k % 4] = 1'b1;
        end

        // Single write from requester 2 only.
        req = 4'b0100;
        din[23:16] = 8'hA5;
        check("single_c0_busy", 32'(busy), 32'h0);
        run_txn(2, 8'hA5, "single");

        // Data isolation: din[1] changes after capture.
        req = 4'b0010;
        din[15:8] = 8'h3C;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 2) din[15:8] = 8'hFF;
            if (c <= 5) check($sformatf("iso_d_c%0d", c), 32'(d_out), 32'h3C);
            check($sformatf("iso_ack_c%0d", c), 32'(ack), (c == 5) ? 32'h2 : 32'h0);
            if (c == 5) req[1] = 1'b0;
        end

        // Reset asserted mid-pulse.
        req = 4'b0001;
        tick();
        tick();
        check("midrst_en_before", 32'(en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_en", 32'(en), 32'h0);
        check("midrst_d", 32'(d_out), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        req = 4'b0000;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("post_rst_ack_%0d", c), 32'(ack), 32'h0);
            check($sformatf("post_rst_busy_%0d", c), 32'(busy), 32'h0);
        end

        // Parameter sweep instance: SETUP=3, PULSE=1, HOLD=2.
        req2 = 4'b1000;
        din2 = 32'h5A000000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("sweep_en_c%0d", c), 32'(en2), 32'(c == 4));
            check($sformatf("sweep_ack_c%0d", c), 32'(ack2), (c == 7) ? 32'h8 : 32'h0);
            check($sformatf("sweep_busy_c%0d", c), 32'(busy2), 32'(c <= 7));
            if (c <= 7) check($sformatf("sweep_d_c%0d", c), 32'(d_out2), 32'h5A);
            if (c == 7) req2 = 4'b0000;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
